uart_rx: RTL and testbench
==========================

# uart_rx

Oversampling UART receiver that deserialises an asynchronous serial line into parallel data words. It consumes the 16×-oversampling `tick` strobe produced by the baud-rate generator, so one bit period is exactly 16 ticks. It reports each completed frame with a one-cycle done strobe plus framing and parity error flags. Its parallel side feeds the receive FIFO or the host interface.

## Interface
Parameters:
- `DBIT`, 8: data bits per frame; legal range 5–9.
- `SB_TICK`, 16: ticks in the stop bit (16, 24 or 32 for 1, 1.5 or 2 stop bits).
- `PAR_EN`, 0: 1 inserts a parity bit after the data bits.
- `PAR_ODD`, 0: 1 selects odd parity, 0 selects even; ignored when `PAR_EN`=0.

Ports:
- `clk` in, 1: system clock; all logic on its rising edge.
- `reset` in, 1: synchronous, active-high reset.
- `s_tick` in, 1: oversampling strobe, one `clk` cycle wide, 16 per bit period.
- `rx` in, 1: asynchronous serial line; idle level is high.
- `dout` out, `DBIT`: last received word, LSB = first data bit received.
- `rx_done_tick` out, 1: one-cycle pulse when a frame completes.
- `frame_err` out, 1: stop bit was sampled low in the last frame.
- `par_err` out, 1: parity mismatch in the last frame; always 0 when `PAR_EN`=0.

## Operation
- `rx` passes through a 2-FF synchronizer whose flops reset to 1. All FSM decisions use the synchronized `rx_s`.
- Registers:
  - `state`
  - `s_reg` (4 bits, or 5 bits when `SB_TICK` > 16): tick counter
  - `n_reg` (ceil(log2(`DBIT`)) bits): bit counter
  - `b_reg` (`DBIT` bits): shift register
  - `p_reg` (1 bit): parity accumulator
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - When `rx_s`=0, go to START and clear `s_reg`.
  - `s_tick` is not required to leave IDLE.
- START, on each `s_tick`:
  - If `s_reg`=7 (mid start bit) and `rx_s`=0: go to DATA, clear `s_reg`, `n_reg` and `p_reg`.
  - If `s_reg`=7 and `rx_s`=1: false start. Return to IDLE with no strobe and no flag change.
  - Otherwise increment `s_reg`.
- DATA, on each `s_tick`:
  - If `s_reg`=15: clear `s_reg`, set `b_reg` ← {`rx_s`, `b_reg`[DBIT-1:1]} and `p_reg` ^= `rx_s`.
  - At that sample, if `n_reg`=DBIT-1, go to PARITY when `PAR_EN`=1, else to STOP. Otherwise increment `n_reg`.
  - Otherwise increment `s_reg`.
- PARITY, on each `s_tick`:
  - When `s_reg`=15, capture `rx_s` into the accumulator and go to STOP with `s_reg` cleared.
  - Error condition is (`p_reg` ^ `rx_s` ^ `PAR_ODD`) = 1.
- STOP, on each `s_tick`:
  - When `s_reg`=SB_TICK-1, return to IDLE.
  - In that same transition, load `dout` ← `b_reg`, `frame_err` ← ~`rx_s`, `par_err` ← the parity result, and pulse `rx_done_tick`.
- Error flags are updated only at frame completion and hold until the next completion.
- `s_tick` arriving when no counter action is due is ignored. Counters advance only on `s_tick`.
- `reset` asserted in any state:
  - Next cycle: `state`=IDLE; all counters, `dout`, `rx_done_tick`, `frame_err` and `par_err` are 0; synchronizer flops are 1.
  - A partial frame is discarded without a strobe.

## Timing
- Reset values: `dout`=0, `rx_done_tick`=0, `frame_err`=0, `par_err`=0.
- Input latency: 2 `clk` cycles from an `rx` edge to `rx_s`.
- `dout`, `frame_err`, `par_err` and `rx_done_tick` are registered. They change in the `clk` cycle after the `s_tick` that completes STOP.
- `rx_done_tick` is high for exactly 1 `clk` cycle per frame.
- With `SB_TICK`=16, the return to IDLE occurs at mid stop bit. A start edge of a back-to-back frame is therefore detected with no lost frame.
- A break condition (line held low) yields a frame with `dout`=0 and `frame_err`=1. The FSM then re-enters START only after `rx_s` goes high and then low again.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP)
  - `OVERSAMPLE`=16
  - `START_MID`=7
- The synchronizer is a separate sub-module, `sync_2ff`, with a reset-value parameter. The baud generator and the transmitter reuse it.
- Everything else stays flat in `uart_rx`.

## Test plan
Every test pairs `uart_rx` with the baud generator at `dvsr`=3, giving a tick every 4 clocks and a 64-clock bit period.
- Frame 8N1 with data 0xA5, `PAR_EN`=0: one `rx_done_tick`; `dout`=0xA5, `frame_err`=0, `par_err`=0.
- Low glitch on `rx` of 3 bit-ticks, then high: no `rx_done_tick`; FSM back in IDLE; outputs unchanged.
- 0x3C with stop bit forced low: `dout`=0x3C, `frame_err`=1. The following good frame 0x01 gives `frame_err`=0.
- `PAR_EN`=1, `PAR_ODD`=0:
  - 0x07 with parity bit 1: `par_err`=0.
  - Same data with parity bit 0: `par_err`=1.
- Back-to-back 0x00, 0xFF, 0x55 with no idle gap: three strobes, in that data order, with no errors.
- `reset` pulsed mid-DATA of 0x81, then a clean 0x42 frame: no strobe for the aborted frame; next strobe has `dout`=0x42.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and oversampling constants.
package uart_pkg;

  // Receiver frame states, in the order a frame walks through them.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Ticks per bit period; the baud generator emits this many strobes per bit.
  localparam int OVERSAMPLE = 16;
  // Tick count at the middle of the start bit.
  localparam int START_MID = 7;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a
// configurable reset value so idle-high lines stay idle through reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the input through two flops; both start at the line's idle level.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      // NOTE: non-blocking so q takes meta's old value and the chain really is two stages deep.
      meta <= d;
      q    <= meta;
    end
  end

endmodule : sync_2ff

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: synchronizes rx, walks a frame through
// START/DATA/PARITY/STOP on s_tick, and reports each frame with a one-cycle
// strobe plus framing and parity error flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PAR_EN  = 0,
  parameter int PAR_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            par_err
);

  localparam int SB_W = (SB_TICK > 16) ? 5 : 4;
  localparam int NB_W = $clog2(DBIT);

  localparam logic [SB_W-1:0] MID_CNT  = SB_W'(START_MID);
  localparam logic [SB_W-1:0] BIT_LAST = SB_W'(OVERSAMPLE - 1);
  localparam logic [SB_W-1:0] SB_LAST  = SB_W'(SB_TICK - 1);
  localparam logic [NB_W-1:0] N_LAST   = NB_W'(DBIT - 1);
  localparam logic            USE_PAR  = (PAR_EN != 0);
  localparam logic            ODD      = (PAR_ODD != 0);

  rx_state_t       state;
  logic [SB_W-1:0] s_reg;
  logic [NB_W-1:0] n_reg;
  logic [DBIT-1:0] b_reg;
  logic            p_reg;
  logic            rx_s;
  // Set once the line has been seen high; a stop bit sampled low clears it
  // so a held break produces one frame rather than a stream of them.
  logic            line_armed;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // Frame FSM with counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      s_reg        <= '0;
      n_reg        <= '0;
      b_reg        <= '0;
      p_reg        <= 1'b0;
      line_armed   <= 1'b0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      par_err      <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_s) begin
            line_armed <= 1'b1;
          end else if (line_armed) begin
            state <= START;
            s_reg <= '0;
          end
        end
        START: begin
          if (s_tick) begin
            if (s_reg == MID_CNT) begin
              if (!rx_s) begin
                state <= DATA;
                s_reg <= '0;
                n_reg <= '0;
                p_reg <= 1'b0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s_reg <= s_reg + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s_reg == BIT_LAST) begin
              s_reg <= '0;
              b_reg <= {rx_s, b_reg[DBIT-1:1]};
              p_reg <= p_reg ^ rx_s;
              if (n_reg == N_LAST) begin
                state <= USE_PAR ? PARITY : STOP;
              end else begin
                n_reg <= n_reg + 1'b1;
              end
            end else begin
              s_reg <= s_reg + 1'b1;
            end
          end
        end
        PARITY: begin
          if (s_tick) begin
            if (s_reg == BIT_LAST) begin
              s_reg <= '0;
              p_reg <= p_reg ^ rx_s;
              state <= STOP;
            end else begin
              s_reg <= s_reg + 1'b1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s_reg == SB_LAST) begin
              state        <= IDLE;
              line_armed   <= rx_s;
              dout         <= b_reg;
              frame_err    <= ~rx_s;
              par_err      <= USE_PAR & (p_reg ^ ODD);
              rx_done_tick <= 1'b1;
            end else begin
              s_reg <= s_reg + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: an 8N1 instance and an 8E1 instance share a
// clock, reset and a tick every 4 clocks (64-clock bit period).
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic [1:0] tick_cnt = '0;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic [7:0] dout_a, dout_b;
  logic       done_a, done_b, ferr_a, ferr_b, perr_a, perr_b;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } strobe_t;

  strobe_t q_a[$];
  strobe_t q_b[$];
  int run_a = 0, max_run_a = 0;

  uart_rx #(.DBIT(8), .SB_TICK(16), .PAR_EN(0), .PAR_ODD(0)) dut_a (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx_a),
    .dout(dout_a), .rx_done_tick(done_a), .frame_err(ferr_a), .par_err(perr_a)
  );

  uart_rx #(.DBIT(8), .SB_TICK(16), .PAR_EN(1), .PAR_ODD(0)) dut_b (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx_b),
    .dout(dout_b), .rx_done_tick(done_b), .frame_err(ferr_b), .par_err(perr_b)
  );

  always #5 clk = ~clk;

  // Baud generator stand-in with dvsr=3: one-cycle tick every 4 clocks.
  always @(posedge clk) begin
    tick_cnt <= tick_cnt + 2'd1;
    s_tick   <= (tick_cnt == 2'd2);
  end

  // Record every completion strobe and the longest strobe run.
  always @(negedge clk) begin
    if (done_a) begin
      q_a.push_back('{d: dout_a, fe: ferr_a, pe: perr_a});
      run_a = run_a + 1;
      if (run_a > max_run_a) max_run_a = run_a;
    end else begin
      run_a = 0;
    end
    if (done_b) q_b.push_back('{d: dout_b, fe: ferr_b, pe: perr_b});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rx_b = v;
    else rx_a = v;
  endtask

  task automatic hold(input bit sel, input logic v, input int nbits);
    drive(sel, v);
    repeat (nbits * BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] data, input bit with_par,
                            input logic par_bit, input logic stop_val);
    hold(sel, 1'b0, 1);
    for (int i = 0; i < 8; i++) hold(sel, data[i], 1);
    if (with_par) hold(sel, par_bit, 1);
    hold(sel, stop_val, 1);
    drive(sel, 1'b1);
  endtask

  task automatic expect_strobe(input bit sel, input string name, input logic [7:0] d,
                               input logic fe, input logic pe);
    strobe_t s;
    int n;
    n = sel ? q_b.size() : q_a.size();
    check({name, "_present"}, 32'(n != 0), 32'd1);
    if (n != 0) begin
      s = sel ? q_b.pop_front() : q_a.pop_front();
      check({name, "_dout"}, 32'(s.d), 32'(d));
      check({name, "_ferr"}, 32'(s.fe), 32'(fe));
      check({name, "_perr"}, 32'(s.pe), 32'(pe));
    end
  endtask

  typedef struct {
    string      name;
    bit         sel;
    logic [7:0] data;
    bit         with_par;
    logic       par_bit;
    logic       stop_val;
    logic [7:0] exp_dout;
    logic       exp_fe;
    logic       exp_pe;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{"a5_8n1",   1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{"3c_stop0", 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
    vecs[2] = '{"01_good",  1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[3] = '{"07_par1",  1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    vecs[4] = '{"07_par0",  1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 8'h07, 1'b0, 1'b1};

    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dout", 32'(dout_a), 32'h0);
    check("rst_done", 32'(done_a), 32'h0);
    check("rst_ferr", 32'(ferr_a), 32'h0);
    check("rst_perr", 32'(perr_b), 32'h0);
    repeat (BIT_CLKS) @(negedge clk);

    // Table of single frames with an idle gap after each.
    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].sel, vecs[i].data, vecs[i].with_par, vecs[i].par_bit, vecs[i].stop_val);
      repeat (2 * BIT_CLKS) @(negedge clk);
      check({vecs[i].name, "_count"}, 32'(vecs[i].sel ? q_b.size() : q_a.size()), 32'd1);
      expect_strobe(vecs[i].sel, vecs[i].name, vecs[i].exp_dout, vecs[i].exp_fe, vecs[i].exp_pe);
    end

    // Short low glitch: false start, no strobe, outputs hold 0x01.
    drive(1'b0, 1'b0);
    repeat (12) @(negedge clk);
    drive(1'b0, 1'b1);
    repeat (3 * BIT_CLKS) @(negedge clk);
    check("glitch_count", 32'(q_a.size()), 32'd0);
    check("glitch_state", 32'(dut_a.state), 32'(IDLE));
    check("glitch_dout", 32'(dout_a), 32'h01);
    check("glitch_ferr", 32'(ferr_a), 32'h0);

    // Break: line held low for 14 bit times gives exactly one frame.
    hold(1'b0, 1'b0, 14);
    check("break_count", 32'(q_a.size()), 32'd1);
    expect_strobe(1'b0, "break", 8'h00, 1'b1, 1'b0);
    hold(1'b0, 1'b1, 2);
    check("break_after", 32'(q_a.size()), 32'd0);

    // Back-to-back frames with no idle gap.
    send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
    repeat (2 * BIT_CLKS) @(negedge clk);
    check("b2b_count", 32'(q_a.size()), 32'd3);
    expect_strobe(1'b0, "b2b_00", 8'h00, 1'b0, 1'b0);
    expect_strobe(1'b0, "b2b_ff", 8'hFF, 1'b0, 1'b0);
    expect_strobe(1'b0, "b2b_55", 8'h55, 1'b0, 1'b0);

    // Reset in mid-DATA of 0x81 discards the frame; then a clean 0x42.
    hold(1'b0, 1'b0, 1);
    hold(1'b0, 1'b1, 1);
    hold(1'b0, 1'b0, 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b1);
    @(negedge clk);
    check("rst2_dout", 32'(dout_a), 32'h0);
    check("rst2_state", 32'(dut_a.state), 32'(IDLE));
    repeat (2 * BIT_CLKS) @(negedge clk);
    check("rst2_nostrobe", 32'(q_a.size()), 32'd0);
    send_frame(1'b0, 8'h42, 1'b0, 1'b0, 1'b1);
    repeat (2 * BIT_CLKS) @(negedge clk);
    check("rst2_count", 32'(q_a.size()), 32'd1);
    expect_strobe(1'b0, "after_rst", 8'h42, 1'b0, 1'b0);

    check("done_width", 32'(max_run_a), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_rx
